// File: rtl/transfer_reg_assembler.sv
// Serial-to-parallel transfer register: assembles WIDTH bits LSB-first and hands the word
// to the buffer-register write path via TWREQ/WACK. Optional parity: TRANSFER_REG_ASSEMBLER_PARITY_EN.
module transfer_reg_assembler #(
  parameter int WIDTH = 9
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         CLTR,
  input  logic                         SRTR,
  input  logic                         SDIN,
  input  logic                         STO,
  input  logic                         WACK,
  output logic [WIDTH-1:0]             TW,
  output logic                         TWREQ,
  output logic                         TRFULL,
  output logic                         OVR,
`ifdef TRANSFER_REG_ASSEMBLER_PARITY_EN
  output logic                         TWP,
`endif
  output logic [$clog2(WIDTH+1)-1:0]   BITCNT
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SHIFT,
    ST_FULL,
    ST_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tw_q, tw_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             twreq_q, twreq_d;
  logic             trfull_q, trfull_d;
  logic             ovr_q, ovr_d;
  logic             twp_q, twp_d;

  always_comb begin
    state_d  = state_q;
    tw_d     = tw_q;
    bitcnt_d = bitcnt_q;
    twreq_d  = twreq_q;
    trfull_d = trfull_q;
    ovr_d    = ovr_q;
    twp_d    = twp_q;

    if (CLTR) begin
      state_d  = ST_EMPTY;
      tw_d     = '0;
      bitcnt_d = '0;
      twreq_d  = 1'b0;
      trfull_d = 1'b0;
      ovr_d    = 1'b0;
      twp_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY, ST_SHIFT: begin
          // STO is deliberately ignored here, even alongside the final shift.
          if (SRTR) begin
            tw_d     = {SDIN, tw_q[WIDTH-1:1]};
            bitcnt_d = bitcnt_q + CW'(1);
            twp_d    = twp_q ^ SDIN;
            if (bitcnt_q == CW'(WIDTH-1)) begin
              state_d  = ST_FULL;
              trfull_d = 1'b1;
            end else begin
              state_d  = ST_SHIFT;
            end
          end
        end
        ST_FULL: begin
          if (SRTR) ovr_d = 1'b1;
          if (STO) begin
            state_d = ST_WRITE;
            twreq_d = 1'b1;
          end
        end
        ST_WRITE: begin
          if (SRTR) ovr_d = 1'b1;
          if (WACK) begin
            state_d  = ST_EMPTY;
            tw_d     = '0;
            bitcnt_d = '0;
            twreq_d  = 1'b0;
            trfull_d = 1'b0;
            twp_d    = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= ST_EMPTY;
      tw_q     <= '0;
      bitcnt_q <= '0;
      twreq_q  <= 1'b0;
      trfull_q <= 1'b0;
      ovr_q    <= 1'b0;
      twp_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      tw_q     <= tw_d;
      bitcnt_q <= bitcnt_d;
      twreq_q  <= twreq_d;
      trfull_q <= trfull_d;
      ovr_q    <= ovr_d;
      twp_q    <= twp_d;
    end
  end

  assign TW     = tw_q;
  assign BITCNT = bitcnt_q;
  assign TWREQ  = twreq_q;
  assign TRFULL = trfull_q;
  assign OVR    = ovr_q;

`ifdef TRANSFER_REG_ASSEMBLER_PARITY_EN
  assign TWP = twp_q;
`else
  logic unused_twp;
  assign unused_twp = twp_q;
`endif

endmodule

// File: tb/tb_transfer_reg_assembler.sv
// Self-checking bench for transfer_reg_assembler: directed scenarios then randomized
// traffic, all compared against a queue-based word model.
module tb_transfer_reg_assembler;

  localparam int WIDTH = 9;
  localparam int CW    = $clog2(WIDTH+1);

  logic             CLK = 1'b0;
  logic             RESETN = 1'b0;
  logic             CLTR = 1'b0, SRTR = 1'b0, SDIN = 1'b0, STO = 1'b0, WACK = 1'b0;
  logic [WIDTH-1:0] TW;
  logic             TWREQ, TRFULL, OVR;
  logic [CW-1:0]    BITCNT;
`ifdef TRANSFER_REG_ASSEMBLER_PARITY_EN
  logic             TWP;
`endif

  transfer_reg_assembler #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .CLTR   (CLTR),
    .SRTR   (SRTR),
    .SDIN   (SDIN),
    .STO    (STO),
    .WACK   (WACK),
    .TW     (TW),
    .TWREQ  (TWREQ),
    .TRFULL (TRFULL),
    .OVR    (OVR),
`ifdef TRANSFER_REG_ASSEMBLER_PARITY_EN
    .TWP    (TWP),
`endif
    .BITCNT (BITCNT)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the bits received so far (in arrival order), plus request and overrun flags.
  bit m_bits[$];
  bit m_req;
  bit m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [WIDTH-1:0] model_tw();
    logic [WIDTH-1:0] w = '0;
    int unsigned n = m_bits.size();
    for (int unsigned i = 0; i < n; i++)
      w[WIDTH - n + i] = m_bits[i];
    return w;
  endfunction

  function automatic int unsigned ones(input logic [WIDTH-1:0] w);
    int unsigned c = 0;
    for (int unsigned i = 0; i < WIDTH; i++) c += w[i];
    return c;
  endfunction

  task automatic model_clear();
    m_bits.delete();
    m_req = 1'b0;
  endtask

  task automatic model_step(input bit srtr, sdin, sto, wack, cltr);
    if (cltr) begin
      model_clear();
      m_ovr = 1'b0;
    end else if (m_req) begin
      if (srtr) m_ovr = 1'b1;
      if (wack) model_clear();
    end else if (m_bits.size() == WIDTH) begin
      if (srtr) m_ovr = 1'b1;
      if (sto) m_req = 1'b1;
    end else if (srtr) begin
      m_bits.push_back(sdin);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [WIDTH-1:0] etw = model_tw();
    check({ctx, ".TW"},     32'(TW),     32'(etw));
    check({ctx, ".BITCNT"}, 32'(BITCNT), 32'(m_bits.size()));
    check({ctx, ".TRFULL"}, 32'(TRFULL), 32'(m_bits.size() == WIDTH));
    check({ctx, ".TWREQ"},  32'(TWREQ),  32'(m_req));
    check({ctx, ".OVR"},    32'(OVR),    32'(m_ovr));
`ifdef TRANSFER_REG_ASSEMBLER_PARITY_EN
    check({ctx, ".TWP"},    32'(TWP),    32'(ones(etw) % 2 == 0));
`endif
  endtask

  task automatic step(input string ctx, input bit srtr, sdin, sto, wack, cltr);
    SRTR = srtr; SDIN = sdin; STO = sto; WACK = wack; CLTR = cltr;
    @(posedge CLK);
    model_step(srtr, sdin, sto, wack, cltr);
    #1;
    check_all(ctx);
  endtask

  task automatic shift_word(input string ctx, input logic [WIDTH-1:0] w);
    for (int unsigned i = 0; i < WIDTH; i++) step(ctx, 1'b1, w[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned req_cycles;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] seq;
    seq = 9'b101001101;

    m_ovr = 1'b0;
    model_clear();
    #2;
    check_all("reset");
    #10 RESETN = 1'b1;

    // Sequence 1,0,1,1,0,0,1,0,1 (first bit first) lands as 9'b101001101.
    shift_word("seq", seq);
    check("seq.TW_const", 32'(TW), 32'h14D);
    check("seq.BITCNT_const", 32'(BITCNT), 32'd9);

    // Handshake: STO, three cycles WACK low, one cycle WACK high.
    req_cycles = 0;
    held = TW;
    step("sto", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    req_cycles += TWREQ;
    for (int i = 0; i < 3; i++) begin
      step("wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      req_cycles += TWREQ;
      check("wait.TW_stable", 32'(TW), 32'(held));
    end
    step("wack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    req_cycles += TWREQ;
    check("handshake.req_cycles", req_cycles, 32'd4);

    // Overrun in FULL, sticky across write, cleared by CLTR.
    shift_word("ovr", 9'h0A5);
    step("ovr.x1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ovr.x2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ovr.sto", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ovr.wack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr.sticky", 32'(OVR), 32'd1);
    step("ovr.cltr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // CLTR beats SRTR; STO mid-word is ignored.
    for (int i = 0; i < 4; i++) step("pre", 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    step("cltr_srtr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("five", 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    step("sto_shift", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // STO coincident with the final shift is also ignored.
    for (int i = 0; i < 3; i++) step("fill", 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    step("last_sto", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("after_last");

    // Asynchronous reset mid-handshake.
    step("ar.sto", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3 RESETN = 1'b0;
    m_ovr = 1'b0;
    model_clear();
    #1 check_all("async_rst");
    #1 RESETN = 1'b1;
    step("ar.wack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef TRANSFER_REG_ASSEMBLER_PARITY_EN
    check("par.reset", 32'(TWP), 32'd1);
    shift_word("par7", 9'b000000111);
    check("par.w7", 32'(TWP), 32'd0);
    step("par.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    shift_word("par3", 9'b000000011);
    check("par.w3", 32'(TWP), 32'd1);
    step("par.clr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           $urandom_range(99) < 60,
           1'($urandom),
           $urandom_range(99) < 20,
           $urandom_range(99) < 25,
           $urandom_range(199) < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    check("timeout", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
